// File: rtl/led_pattern_gen.sv
// LED pattern generator: programmable tick prescaler driving four display modes
// (flash, rotate left, rotate right, ping-pong) plus a one-cycle tick strobe.
module led_pattern_gen #(
    parameter int unsigned NB_LEDS  = 4,
    parameter int unsigned NB_COUNT = 32
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic [1:0]          i_mode,
    input  logic [NB_COUNT-1:0] i_limit,
    output logic [NB_LEDS-1:0]  o_led,
    output logic                o_tick,
    output logic                o_dir
);

    typedef enum logic [1:0] {
        ModeFlash    = 2'd0,
        ModeRotL     = 2'd1,
        ModeRotR     = 2'd2,
        ModePingPong = 2'd3
    } mode_e;

    mode_e               mode_q, mode_d;
    logic [NB_COUNT-1:0] cnt_q, cnt_d;
    logic                dir_q, dir_d;
    logic [NB_LEDS-1:0]  led_q, led_d;
    logic                tick_q, tick_d;

    function automatic logic [NB_LEDS-1:0] seed_of(input mode_e m);
        return (m == ModeFlash) ? '0 : NB_LEDS'(1);
    endfunction

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            mode_q <= ModeFlash;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            led_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            led_q  <= led_d;
            tick_q <= tick_d;
        end
    end

    // Next state: mode change beats tick, tick beats hold.
    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        led_d  = led_q;
        tick_d = 1'b0;

        if (mode_e'(i_mode) != mode_q) begin
            mode_d = mode_e'(i_mode);
            cnt_d  = '0;
            dir_d  = 1'b0;
            led_d  = seed_of(mode_e'(i_mode));
        end else if (i_valid) begin
            // >= so that lowering the limit below the count fires at once.
            if (cnt_q >= i_limit) begin
                tick_d = 1'b1;
                cnt_d  = '0;
                if (mode_q != ModeFlash && led_q == '0) begin
                    // A pattern that lost its lit bit is restarted from the seed.
                    led_d = seed_of(mode_q);
                end else begin
                    unique case (mode_q)
                        ModeFlash: led_d = ~led_q;
                        ModeRotL:  led_d = {led_q[NB_LEDS-2:0], led_q[NB_LEDS-1]};
                        ModeRotR:  led_d = {led_q[0], led_q[NB_LEDS-1:1]};
                        ModePingPong: begin
                            // Reverse within the same tick so the end is never held.
                            if (!dir_q) begin
                                if (led_q[NB_LEDS-1]) begin
                                    dir_d = 1'b1;
                                    led_d = led_q >> 1;
                                end else begin
                                    led_d = led_q << 1;
                                end
                            end else begin
                                if (led_q[0]) begin
                                    dir_d = 1'b0;
                                    led_d = led_q << 1;
                                end else begin
                                    led_d = led_q >> 1;
                                end
                            end
                        end
                        default: led_d = led_q;
                    endcase
                end
            end else begin
                cnt_d = cnt_q + NB_COUNT'(1);
            end
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        o_led  = led_q;
        o_tick = tick_q;
        o_dir  = dir_q;
    end

endmodule
